// File: rtl/csa_pkg.sv
// Shared sizing and the per-block candidate record for the carry-select subtractor.
package csa_pkg;
   localparam int CSA_WIDTH = 64;
   localparam int CSA_BLOCK = 16;
   localparam int CSA_NBLK  = CSA_WIDTH / CSA_BLOCK;

   // Both speculative results of one block, for carry-in 0 and carry-in 1.
   typedef struct packed {
      logic [CSA_BLOCK-1:0] diff0;
      logic [CSA_BLOCK-1:0] diff1;
      logic                 c0;
      logic                 c1;
   } blk_cand_t;

   function automatic int nblk(input int width, input int block);
      return width / block;
   endfunction
endpackage

// File: rtl/csa_block_sub.sv
// One carry-select block: adds an a-slice to an inverted b-slice for both possible carry-ins.
module csa_block_sub
   import csa_pkg::*;
(
   input  logic [CSA_BLOCK-1:0] i_a,
   input  logic [CSA_BLOCK-1:0] i_nb,
   output blk_cand_t            o_cand
);
   logic [CSA_BLOCK:0] w_sum0;
   logic [CSA_BLOCK:0] w_sum1;

   // a + ~b + 1 never exceeds BLOCK+1 bits, so the top bit is a clean carry-out.
   assign w_sum0 = {1'b0, i_a} + {1'b0, i_nb};
   assign w_sum1 = w_sum0 + {{CSA_BLOCK{1'b0}}, 1'b1};

   assign o_cand.diff0 = w_sum0[CSA_BLOCK-1:0];
   assign o_cand.c0    = w_sum0[CSA_BLOCK];
   assign o_cand.diff1 = w_sum1[CSA_BLOCK-1:0];
   assign o_cand.c1    = w_sum1[CSA_BLOCK];
endmodule

// File: rtl/csa64_sub_pipe.sv
// Two-stage carry-select subtractor: S1 holds block candidates, S2 holds the resolved
// difference and flags.
module csa64_sub_pipe
   import csa_pkg::*;
#(
   parameter int WIDTH = CSA_WIDTH,
   parameter int BLOCK = CSA_BLOCK
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             zero,
   output logic             lts
);
   localparam int NBLK = nblk(WIDTH, BLOCK);

   // The candidate record is sized by the package block width.
   if (BLOCK != CSA_BLOCK || (WIDTH % BLOCK) != 0) begin : g_bad_cfg
      $error("csa64_sub_pipe: BLOCK must equal CSA_BLOCK and divide WIDTH");
   end

   logic [WIDTH-1:0] w_nb;
   blk_cand_t        w_cand [NBLK];
   blk_cand_t        r_s1_cand [NBLK];
   logic             r_s1_valid;
   logic             r_s1_amsb;
   logic             r_s1_bmsb;
   logic             r_rdy_en;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_diff;
   logic             r_bout;
   logic             r_zero;
   logic             r_lts;
   logic [WIDTH-1:0] w_diff;
   logic             w_bout;
   logic             w_ovf;
   logic             w_s2_free;
   logic             w_s2_load;
   logic             w_in_fire;

   assign w_nb = ~b;

   for (genvar gi = 0; gi < NBLK; gi++) begin : g_blk
      csa_block_sub u_blk (
         .i_a    (a[gi*BLOCK +: BLOCK]),
         .i_nb   (w_nb[gi*BLOCK +: BLOCK]),
         .o_cand (w_cand[gi])
      );
   end

   // Handshake: a transfer happens on a side whenever valid and ready are both high at
   // the rising edge. S2 is free when empty or being drained this cycle; S1 may accept
   // when empty or when its content moves to S2 in the same cycle. in_ready depends only
   // on registered state and out_ready, never on in_valid, and stays low until the first
   // edge after reset.
   assign w_s2_free = !r_out_valid || out_ready;
   assign w_s2_load = r_s1_valid && w_s2_free;
   assign in_ready  = r_rdy_en && (!r_s1_valid || w_s2_free);
   assign w_in_fire = in_valid && in_ready;

   always_comb begin
      logic [NBLK:0] carry;
      w_diff   = '0;
      carry    = '0;
      carry[0] = 1'b1;
      for (int i = 0; i < NBLK; i++) begin
         w_diff[i*BLOCK +: BLOCK] = carry[i] ? r_s1_cand[i].diff1 : r_s1_cand[i].diff0;
         carry[i+1]               = carry[i] ? r_s1_cand[i].c1    : r_s1_cand[i].c0;
      end
      w_bout = ~carry[NBLK];
   end

   assign w_ovf = (r_s1_amsb != r_s1_bmsb) && (w_diff[WIDTH-1] != r_s1_amsb);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rdy_en   <= 1'b0;
         r_s1_valid <= 1'b0;
         r_s1_amsb  <= 1'b0;
         r_s1_bmsb  <= 1'b0;
         for (int i = 0; i < NBLK; i++) r_s1_cand[i] <= '0;
      end else begin
         r_rdy_en <= 1'b1;
         if (w_in_fire) begin
            r_s1_valid <= 1'b1;
            r_s1_amsb  <= a[WIDTH-1];
            r_s1_bmsb  <= b[WIDTH-1];
            for (int i = 0; i < NBLK; i++) r_s1_cand[i] <= w_cand[i];
         end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_diff      <= '0;
         r_bout      <= 1'b0;
         r_zero      <= 1'b0;
         r_lts       <= 1'b0;
      end else if (w_s2_load) begin
         r_out_valid <= 1'b1;
         r_diff      <= w_diff;
         r_bout      <= w_bout;
         r_zero      <= (w_diff == '0);
         r_lts       <= w_diff[WIDTH-1] ^ w_ovf;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign diff      = r_diff;
   assign bout      = r_bout;
   assign zero      = r_zero;
   assign lts       = r_lts;
endmodule

// File: tb/tb_csa64_sub_pipe.sv
// Directed-vector bench for csa64_sub_pipe: reset, arithmetic corners, backpressure, mid-run reset.
module tb_csa64_sub_pipe;
   localparam int W = 64;

   logic         clock = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] diff;
   logic         bout;
   logic         zero;
   logic         lts;

   int errors = 0;
   int checks = 0;
   // Expected results packed as {bout, zero, lts, diff}.
   logic [W+2:0] exp_q[$];

   always #5 clock = ~clock;

   csa64_sub_pipe dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout),
      .zero      (zero),
      .lts       (lts)
   );

   // Called just after a rising edge; returns just after the edge that accepted the pair.
   task automatic send_pair(input logic [W-1:0] va, input logic [W-1:0] vb, output bit ok);
      ok       = 1'b0;
      a        = va;
      b        = vb;
      in_valid = 1'b1;
      for (int n = 0; n < 20 && !ok; n++) begin
         @(negedge clock);
         if (in_ready === 1'b1) ok = 1'b1;
         @(posedge clock);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset;
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
      end
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready);
      end
      checks++;
      if ({bout, zero, lts, diff} !== '0) begin
         errors++; $display("FAIL reset_outputs: got bout=%b zero=%b lts=%b diff=%h expected all 0",
                            bout, zero, lts, diff);
      end
      reset = 1'b0;
      @(negedge clock);
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL release_in_ready_early: got %b expected 0", in_ready);
      end
      @(posedge clock);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL release_in_ready: got %b expected 1", in_ready);
      end
   endtask

   task automatic test_vectors;
      logic [W-1:0] va [5];
      logic [W-1:0] vb [5];
      logic [W+2:0] ve [5];
      bit           ok;
      va = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0001_0000_0000_0000,
             64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF};
      vb = '{64'hEEEE_DDDD_CCCC_FFFF, 64'h1, 64'h1,
             64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
      ve = '{{3'b000, 64'h1111_2222_3333_0000},
             {3'b101, 64'hFFFF_FFFF_FFFF_FFFF},
             {3'b000, 64'h0000_FFFF_FFFF_FFFF},
             {3'b010, 64'h0},
             {3'b100, 64'hFFFF_FFFF_FFFF_FFFF}};
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         send_pair(va[i], vb[i], ok);
         checks++;
         if (!ok) begin
            errors++; $display("FAIL vec%0d_accept: got in_ready=0 for 20 cycles expected 1", i);
         end
         checks++;
         if (out_valid !== 1'b0) begin
            errors++; $display("FAIL vec%0d_early_valid: got %b expected 0", i, out_valid);
         end
         @(posedge clock);
         #1;
         checks++;
         if (out_valid !== 1'b1) begin
            errors++; $display("FAIL vec%0d_latency: got out_valid=%b expected 1", i, out_valid);
         end
         checks++;
         if ({bout, zero, lts, diff} !== ve[i]) begin
            errors++;
            $display("FAIL vec%0d_result: got bout=%b zero=%b lts=%b diff=%h expected bout=%b zero=%b lts=%b diff=%h",
                     i, bout, zero, lts, diff, ve[i][W+2], ve[i][W+1], ve[i][W], ve[i][W-1:0]);
         end
         @(posedge clock);
         #1;
         checks++;
         if (out_valid !== 1'b0) begin
            errors++; $display("FAIL vec%0d_drain: got out_valid=%b expected 0", i, out_valid);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [W-1:0] ta [4];
      logic [W-1:0] tb_v [4];
      logic [W+2:0] te [4];
      ta   = '{64'd10, 64'd3, 64'h8000_0000_0000_0000, 64'h1234_5678_9ABC_DEF0};
      tb_v = '{64'd3, 64'd10, 64'h1, 64'h1234_5678_9ABC_DEF0};
      te   = '{{3'b000, 64'h7},
               {3'b101, 64'hFFFF_FFFF_FFFF_FFF9},
               {3'b001, 64'h7FFF_FFFF_FFFF_FFFF},
               {3'b010, 64'h0}};
      exp_q.delete();
      for (int i = 0; i < 4; i++) exp_q.push_back(te[i]);
      out_ready = 1'b0;
      @(posedge clock);
      #1;
      fork
         begin : drv
            bit ok;
            for (int i = 0; i < 4; i++) begin
               send_pair(ta[i], tb_v[i], ok);
               checks++;
               if (!ok) begin
                  errors++; $display("FAIL bp_accept%0d: got in_ready=0 for 20 cycles expected 1", i);
               end
            end
         end
         begin : mon
            int           n;
            int           got_n;
            logic [W+2:0] exp_v;
            n = 0;
            @(negedge clock);
            while (out_valid !== 1'b1 && n < 20) begin
               @(negedge clock);
               n++;
            end
            for (int h = 0; h < 3; h++) begin
               if (h > 0) @(negedge clock);
               checks++;
               if (in_ready !== 1'b0) begin
                  errors++; $display("FAIL bp_stall_in_ready%0d: got %b expected 0", h, in_ready);
               end
               checks++;
               if (out_valid !== 1'b1 || {bout, zero, lts, diff} !== exp_q[0]) begin
                  errors++;
                  $display("FAIL bp_hold%0d: got valid=%b result=%h expected valid=1 result=%h",
                           h, out_valid, {bout, zero, lts, diff}, exp_q[0]);
               end
            end
            @(posedge clock);
            #1;
            out_ready = 1'b1;
            got_n = 0;
            for (int c = 0; c < 20 && got_n < 4; c++) begin
               @(negedge clock);
               if (out_valid === 1'b1) begin
                  exp_v = exp_q.pop_front();
                  checks++;
                  if ({bout, zero, lts, diff} !== exp_v) begin
                     errors++;
                     $display("FAIL bp_result%0d: got %h expected %h", got_n, {bout, zero, lts, diff}, exp_v);
                  end
                  got_n++;
               end
            end
            checks++;
            if (got_n != 4) begin
               errors++; $display("FAIL bp_count: got %0d results expected 4", got_n);
            end
            @(negedge clock);
            checks++;
            if (out_valid !== 1'b0) begin
               errors++; $display("FAIL bp_duplicate: got out_valid=%b expected 0", out_valid);
            end
         end
      join
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset_mid;
      bit ok;
      int stale;
      out_ready = 1'b0;
      send_pair(64'd100, 64'd1, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL rm_accept0: got in_ready=0 for 20 cycles expected 1");
      end
      send_pair(64'd200, 64'd2, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL rm_accept1: got in_ready=0 for 20 cycles expected 1");
      end
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b1) begin
         errors++; $display("FAIL rm_inflight: got out_valid=%b expected 1", out_valid);
      end
      #2 reset = 1'b1;
      #1 reset = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL rm_out_valid: got %b expected 0", out_valid);
      end
      checks++;
      if ({bout, zero, lts, diff} !== '0) begin
         errors++; $display("FAIL rm_outputs: got %h expected 0", {bout, zero, lts, diff});
      end
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL rm_in_ready: got %b expected 0", in_ready);
      end
      @(posedge clock);
      #1;
      out_ready = 1'b1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL rm_release_in_ready: got %b expected 1", in_ready);
      end
      stale = 0;
      repeat (6) begin
         @(negedge clock);
         if (out_valid !== 1'b0) stale++;
      end
      checks++;
      if (stale != 0) begin
         errors++; $display("FAIL rm_stale: got %0d cycles with out_valid expected 0", stale);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_vectors();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
